// File: rtl/rtc_reg_bank.sv
// -----------------------------------------------------------------------------
// rtc_reg_bank
//
// Purpose:
//   Register bank for a real-time clock. Software writes into a private staging
//   array, either one register at a time or as a burst from a start address.
//   A commit copies every dirty staged register to the live outputs at once, so
//   the clock/timer fields never show a half-updated time.
//   Register order: seconds, minutes, hours, day, month, year,
//   timer seconds, timer minutes, timer hours.
//
// Configuration macro:
//   RTC_BCD_CHECK_EN - when defined, a write whose data has any nibble above 9
//                      is rejected (wr_err pulse). A rejected burst write does
//                      not advance the burst pointer.
//
// Parameters:
//   WIDTH    - bits per register (multiple of 4)
//   NUM_REGS - number of registers
//   ADDR_W   - address width (2**ADDR_W >= NUM_REGS)
//
// Ports:
//   i_clk         - clock, all state updates on the rising edge
//   i_rst_n       - asynchronous active-low reset
//   i_wr_en       - write strobe
//   i_wr_addr     - single-write address / burst start address
//   i_data_in     - write data
//   i_burst_start - load the burst pointer from i_wr_addr and enter BURST
//   i_commit      - copy all dirty staged registers to o_data_out
//   o_data_out    - live registers, register i at [i*WIDTH +: WIDTH]
//   o_dirty       - bit i set while staging[i] holds an uncommitted value
//   o_wr_err      - one-cycle pulse after a rejected write / burst start
//   o_commit_done - one-cycle pulse in the cycle after a commit
//   o_busy        - high while in BURST
// -----------------------------------------------------------------------------
module rtc_reg_bank #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 9,
    parameter int ADDR_W   = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_wr_en,
    input  logic [ADDR_W-1:0]         i_wr_addr,
    input  logic [WIDTH-1:0]          i_data_in,
    input  logic                      i_burst_start,
    input  logic                      i_commit,
    output logic [NUM_REGS*WIDTH-1:0] o_data_out,
    output logic [NUM_REGS-1:0]       o_dirty,
    output logic                      o_wr_err,
    output logic                      o_commit_done,
    output logic                      o_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [WIDTH-1:0]    r_staging [NUM_REGS];
    logic [WIDTH-1:0]    r_live    [NUM_REGS];
    logic [NUM_REGS-1:0] r_dirty;
    logic [NUM_REGS-1:0] w_dirty_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_wr_err;
    logic                r_commit_done;

    logic                w_addr_ok;
    logic                w_data_ok;
    logic                w_do_write;
    logic [ADDR_W-1:0]   w_write_idx;
    logic                w_load_ptr;
    logic                w_adv_ptr;
    logic                w_err;

    // One extra bit on the compare so it stays correct when 2**ADDR_W == NUM_REGS.
    assign w_addr_ok = ({1'b0, i_wr_addr} < (ADDR_W + 1)'(NUM_REGS));

`ifdef RTC_BCD_CHECK_EN
    always_comb begin
        w_data_ok = 1'b1;
        for (int n = 0; n < WIDTH / 4; n++) begin
            if (i_data_in[n*4 +: 4] > 4'd9) begin
                w_data_ok = 1'b0;
            end
        end
    end
`else
    assign w_data_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and per-cycle write decisions. burst_start always wins over
    // wr_en in the same cycle; a commit always drops the FSM back to IDLE.
    always_comb begin
        w_next_state = r_state;
        w_do_write   = 1'b0;
        w_write_idx  = i_wr_addr;
        w_load_ptr   = 1'b0;
        w_adv_ptr    = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_burst_start) begin
                    if (w_addr_ok) begin
                        w_next_state = BURST;
                        w_load_ptr   = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (i_wr_en) begin
                    if (w_addr_ok && w_data_ok) begin
                        w_do_write = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            BURST: begin
                if (i_burst_start) begin
                    if (w_addr_ok) begin
                        w_load_ptr = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (i_wr_en) begin
                    w_write_idx = r_ptr;
                    if (w_data_ok) begin
                        w_do_write = 1'b1;
                        w_adv_ptr  = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (i_commit) begin
            w_next_state = IDLE;
        end
    end

    // A commit clears every dirty bit, but a write landing on the same edge
    // re-marks its register because it was not part of that commit.
    always_comb begin
        w_dirty_next = i_commit ? '0 : r_dirty;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_do_write && (w_write_idx == ADDR_W'(i))) begin
                w_dirty_next[i] = 1'b1;
            end
        end
    end

    // Staging and live arrays. The commit copies pre-edge staging values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_staging[i] <= '0;
                r_live[i]    <= '0;
            end
            r_dirty <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_do_write && (w_write_idx == ADDR_W'(i))) begin
                    r_staging[i] <= i_data_in;
                end
                if (i_commit && r_dirty[i]) begin
                    r_live[i] <= r_staging[i];
                end
            end
            r_dirty <= w_dirty_next;
        end
    end

    // Burst pointer wraps from the last register back to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_load_ptr) begin
            r_ptr <= i_wr_addr;
        end else if (w_adv_ptr) begin
            r_ptr <= (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_err      <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            r_wr_err      <= w_err;
            r_commit_done <= i_commit;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_data_out[g*WIDTH +: WIDTH] = r_live[g];
    end

    assign o_dirty       = r_dirty;
    assign o_wr_err      = r_wr_err;
    assign o_commit_done = r_commit_done;
    assign o_busy        = (r_state == BURST);

endmodule

// File: tb/tb_rtc_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_rtc_reg_bank
//
// Purpose:
//   Self-checking bench for rtc_reg_bank. Keeps a behavioural model of the
//   staging/live arrays, dirty bits, burst pointer and burst mode, advanced
//   once per rising edge, and compares the DUT outputs against it and against
//   hand-derived constants for the directed scenarios.
//   Honours RTC_BCD_CHECK_EN when defined for the build.
// -----------------------------------------------------------------------------
module tb_rtc_reg_bank;

    localparam int WIDTH    = 8;
    localparam int NUM_REGS = 9;
    localparam int ADDR_W   = 4;

`ifdef RTC_BCD_CHECK_EN
    localparam bit BCD_EN = 1'b1;
`else
    localparam bit BCD_EN = 1'b0;
`endif

    logic                      clk;
    logic                      rst_n;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [WIDTH-1:0]          data_in;
    logic                      burst_start;
    logic                      commit;
    logic [NUM_REGS*WIDTH-1:0] data_out;
    logic [NUM_REGS-1:0]       dirty;
    logic                      wr_err;
    logic                      commit_done;
    logic                      busy;

    int tests_run = 0;
    int failures  = 0;

    // Reference model state.
    logic [7:0] m_stage [NUM_REGS];
    logic [7:0] m_live  [NUM_REGS];
    bit         m_dirty [NUM_REGS];
    int         m_ptr;
    bit         m_burst;
    bit         m_err;
    bit         m_done;

    rtc_reg_bank #(
        .WIDTH   (WIDTH),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_data_in    (data_in),
        .i_burst_start(burst_start),
        .i_commit     (commit),
        .o_data_out   (data_out),
        .o_dirty      (dirty),
        .o_wr_err     (wr_err),
        .o_commit_done(commit_done),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit bcd_ok(logic [7:0] d);
        return !BCD_EN || ((d[7:4] <= 4'd9) && (d[3:0] <= 4'd9));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_stage[i] = 8'h00;
            m_live[i]  = 8'h00;
            m_dirty[i] = 1'b0;
        end
        m_ptr   = 0;
        m_burst = 1'b0;
        m_err   = 1'b0;
        m_done  = 1'b0;
    endtask

    // One rising edge of the model, using the inputs sampled on that edge.
    // The commit copies the old staging values before the same-edge write.
    task automatic model_edge(input bit we, input int addr, input logic [7:0] d,
                              input bit bs, input bit cm);
        m_err  = 1'b0;
        m_done = cm;
        if (cm) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (m_dirty[i]) begin
                    m_live[i]  = m_stage[i];
                    m_dirty[i] = 1'b0;
                end
            end
        end
        if (bs) begin
            if (addr < NUM_REGS) begin
                m_ptr   = addr;
                m_burst = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else if (we) begin
            if (m_burst) begin
                if (bcd_ok(d)) begin
                    m_stage[m_ptr] = d;
                    m_dirty[m_ptr] = 1'b1;
                    m_ptr = (m_ptr + 1) % NUM_REGS;
                end else begin
                    m_err = 1'b1;
                end
            end else if (addr < NUM_REGS && bcd_ok(d)) begin
                m_stage[addr] = d;
                m_dirty[addr] = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        if (cm) m_burst = 1'b0;
    endtask

    function automatic logic [83:0] model_vec();
        logic [71:0] f;
        logic [8:0]  dv;
        for (int i = 0; i < NUM_REGS; i++) begin
            f[i*8 +: 8] = m_live[i];
            dv[i]       = m_dirty[i];
        end
        return {f, dv, m_err, m_done, m_burst};
    endfunction

    // Drive one cycle of stimulus, advance the model on the edge, then settle.
    task automatic applyStimulus(input bit we, input logic [3:0] addr, input logic [7:0] d,
                                 input bit bs, input bit cm);
        @(negedge clk);
        wr_en       = we;
        wr_addr     = addr;
        data_in     = d;
        burst_start = bs;
        commit      = cm;
        @(posedge clk);
        model_edge(we, int'(addr), d, bs, cm);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; data_in = '0; burst_start = 1'b0; commit = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({data_out, dirty, wr_err, commit_done, busy} !== 84'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h required 0", {data_out, dirty, wr_err, commit_done, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        applyStimulus(1, 4'd2, 8'h23, 0, 0);
        tests_run++;
        if (dirty !== 9'h004) begin
            failures++;
            $display("[TB] FAIL single_dirty: got %h required 004", dirty);
        end
        tests_run++;
        if (data_out !== 72'd0) begin
            failures++;
            $display("[TB] FAIL single_no_live_change: got %h required 0", data_out);
        end
        applyStimulus(0, 4'd0, 8'h00, 0, 1);
        tests_run++;
        if (data_out[23:16] !== 8'h23 || dirty !== 9'h000 || commit_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_commit: got hours=%h dirty=%h done=%b required 23/000/1",
                     data_out[23:16], dirty, commit_done);
        end
        applyStimulus(0, 4'd0, 8'h00, 0, 0);
        tests_run++;
        if (commit_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_done_pulse: got %b required 0", commit_done);
        end
    endtask

    task automatic test_burst_wrap();
        applyStimulus(0, 4'd7, 8'h00, 1, 0);
        tests_run++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL burst_busy: got %b required 1", busy);
        end
        applyStimulus(1, 4'd3, 8'h11, 0, 0);
        applyStimulus(1, 4'd3, 8'h22, 0, 0);
        applyStimulus(1, 4'd3, 8'h33, 0, 0);
        tests_run++;
        if (dirty !== 9'h181 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL burst_staged: got dirty=%h busy=%b required 181/1", dirty, busy);
        end
        applyStimulus(0, 4'd0, 8'h00, 0, 1);
        tests_run++;
        if (data_out[63:56] !== 8'h11 || data_out[71:64] !== 8'h22 ||
            data_out[7:0] !== 8'h33 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL burst_commit: got r7=%h r8=%h r0=%h busy=%b required 11/22/33/0",
                     data_out[63:56], data_out[71:64], data_out[7:0], busy);
        end
    endtask

    task automatic test_write_commit_same_edge();
        applyStimulus(1, 4'd0, 8'h45, 0, 0);
        applyStimulus(1, 4'd0, 8'h46, 0, 1);
        tests_run++;
        if (data_out[7:0] !== 8'h45 || dirty[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL same_edge_commit: got r0=%h dirty0=%b required 45/1",
                     data_out[7:0], dirty[0]);
        end
        applyStimulus(0, 4'd0, 8'h00, 0, 1);
        tests_run++;
        if (data_out[7:0] !== 8'h46) begin
            failures++;
            $display("[TB] FAIL same_edge_second_commit: got %h required 46", data_out[7:0]);
        end
    endtask

    task automatic test_illegal_addr();
        applyStimulus(1, 4'd1, 8'h12, 0, 0);
        applyStimulus(1, 4'd12, 8'h10, 0, 0);
        tests_run++;
        if (wr_err !== 1'b1 || dirty !== 9'h002) begin
            failures++;
            $display("[TB] FAIL illegal_write: got err=%b dirty=%h required 1/002", wr_err, dirty);
        end
        applyStimulus(0, 4'd0, 8'h00, 1, 0);
        tests_run++;
        if (wr_err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL illegal_err_pulse: got err=%b busy=%b required 0/1", wr_err, busy);
        end
        applyStimulus(0, 4'd0, 8'h00, 0, 1);
        applyStimulus(0, 4'd13, 8'h00, 1, 0);
        tests_run++;
        if (wr_err !== 1'b1 || busy !== 1'b0 || data_out[15:8] !== 8'h12) begin
            failures++;
            $display("[TB] FAIL illegal_burst_start: got err=%b busy=%b r1=%h required 1/0/12",
                     wr_err, busy, data_out[15:8]);
        end
    endtask

    task automatic test_bcd();
        logic [7:0] exp4;
        logic [7:0] exp5;
        exp4 = BCD_EN ? 8'h59 : 8'h5A;
        exp5 = BCD_EN ? 8'h00 : 8'h59;
        applyStimulus(0, 4'd4, 8'h00, 1, 0);
        applyStimulus(1, 4'd0, 8'h5A, 0, 0);
        tests_run++;
        if (wr_err !== BCD_EN) begin
            failures++;
            $display("[TB] FAIL bcd_err: got %b required %b", wr_err, BCD_EN);
        end
        applyStimulus(1, 4'd0, 8'h59, 0, 0);
        applyStimulus(0, 4'd0, 8'h00, 0, 1);
        tests_run++;
        if (data_out[39:32] !== exp4 || data_out[47:40] !== exp5) begin
            failures++;
            $display("[TB] FAIL bcd_landing: got r4=%h r5=%h required %h/%h",
                     data_out[39:32], data_out[47:40], exp4, exp5);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 99) < 55),
                          4'($urandom_range(0, 15)),
                          8'($urandom),
                          ($urandom_range(0, 99) < 10),
                          ($urandom_range(0, 99) < 15));
            tests_run++;
            if ({data_out, dirty, wr_err, commit_done, busy} !== model_vec()) begin
                failures++;
                $display("[TB] FAIL random_step%0d: got %h required %h",
                         n, {data_out, dirty, wr_err, commit_done, busy}, model_vec());
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        applyStimulus(1, 4'd0, 8'h01, 0, 0);
        applyStimulus(1, 4'd1, 8'h02, 0, 0);
        applyStimulus(1, 4'd2, 8'h03, 0, 0);
        applyStimulus(0, 4'd0, 8'h00, 0, 1);
        applyStimulus(0, 4'd5, 8'h00, 1, 0);
        applyStimulus(1, 4'd0, 8'h07, 0, 0);
        @(negedge clk);
        wr_en = 1'b0; burst_start = 1'b0; commit = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({data_out, dirty, wr_err, commit_done, busy} !== 84'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_burst: got %h required 0", {data_out, dirty, wr_err, commit_done, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 4'd0, 8'h00, 0, 1);
        tests_run++;
        if (data_out !== 72'd0 || busy !== 1'b0 || commit_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_then_commit: got data=%h busy=%b done=%b required 0/0/1",
                     data_out, busy, commit_done);
        end
    endtask

    task automatic checkOutput();
        tests_run++;
        if ({data_out, dirty, wr_err, commit_done, busy} !== model_vec()) begin
            failures++;
            $display("[TB] FAIL final_state: got %h required %h",
                     {data_out, dirty, wr_err, commit_done, busy}, model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_write_commit_same_edge();
        test_illegal_addr();
        test_bcd();
        test_random();
        test_reset_mid_burst();
        test_random();
        checkOutput();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/rtc_reg_bank.md
RTC_REG_BANK -- requirements
Module: rtc_reg_bank

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, bits per register (multiple of 4); NUM_REGS, default 9, register count (seconds, minutes, hours, day, month, year, timer seconds, timer minutes, timer hours); ADDR_W, default 4, address width (2**ADDR_W >= NUM_REGS).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 wr_en  input  1  write strobe, sampled each rising edge.
REQ-005 wr_addr  input  ADDR_W  target register for single writes; burst start address.
REQ-006 data_in  input  WIDTH  write data.
REQ-007 burst_start  input  1  loads the burst pointer from wr_addr and enters BURST.
REQ-008 commit  input  1  atomically copies all dirty staged registers to the live outputs.
REQ-009 data_out  output  NUM_REGS*WIDTH  live registers, flat; register i SHALL occupy bits [i*WIDTH +: WIDTH].
REQ-010 dirty  output  NUM_REGS  bit i set means staging[i] has not yet been committed.
REQ-011 wr_err  output  1  one-cycle pulse on a rejected write.
REQ-012 commit_done  output  1  one-cycle pulse in the cycle after a commit is sampled.
REQ-013 busy  output  1  high while the FSM is in BURST.

Function
REQ-014 Writes SHALL land only in an internal staging array; data_out SHALL change only on a commit.
REQ-015 FSM states SHALL be IDLE and BURST.
REQ-016 IDLE transitions:
  - burst_start -> BURST.
  - wr_en -> write staging[wr_addr] and set dirty[wr_addr].
REQ-017 BURST transitions:
  - wr_en -> write staging[ptr], set dirty[ptr], ptr <= ptr+1; wraps from NUM_REGS-1 to 0.
  - wr_addr is ignored while in BURST.
REQ-018 burst_start while in BURST SHALL reload ptr from wr_addr and discard that cycle's wr_en.
REQ-019 burst_start with wr_en in IDLE: the burst start takes priority and the write is discarded.
REQ-020 Commit sampled on edge k (any state):
  - for every i with dirty[i]=1, data_out[i] <= staging[i] at edge k;
  - FSM returns to IDLE;
  - commit_done is high for the cycle following edge k.
REQ-021 A write sampled on the same edge as a commit SHALL NOT be part of that commit:
  - the committed value is the pre-edge staging value;
  - the new write is staged and its dirty bit remains set.
REQ-022 commit with no dirty bits SHALL leave data_out unchanged and still pulse commit_done.
REQ-023 A write with an address >= NUM_REGS (single write or burst start) SHALL be ignored; wr_err pulses for one cycle and no state changes. A burst_start with an illegal address SHALL stay in IDLE.
REQ-024 Staged values SHALL not be altered by a commit; staging[i] keeps its value.
REQ-025 Repeated writes to one register before a commit SHALL keep only the last value.

Reset
REQ-026 While reset=0, the following SHALL be forced asynchronously:
  - staging, data_out, dirty, ptr, wr_err, commit_done and busy to 0;
  - FSM to IDLE.
REQ-027 Reset asserted mid-burst or mid-commit SHALL discard all staged and live data. The first edge after release SHALL be treated as IDLE.

Configuration
REQ-028 Macro RTC_BCD_CHECK_EN SHALL control BCD write checking.
REQ-029 With RTC_BCD_CHECK_EN defined:
  - any write whose data_in has a nibble > 9 SHALL be rejected (wr_err pulse, no staging change, no dirty change);
  - in BURST, a rejected write SHALL NOT advance ptr.
REQ-030 Without RTC_BCD_CHECK_EN, every in-range write SHALL be accepted regardless of data value.

Verification
REQ-031 Single write then commit:
  - reset, write addr 2 = 8'h23 -> dirty=9'h004, data_out unchanged;
  - commit -> hours field=8'h23, dirty=0, commit_done pulses once.
REQ-032 Burst with wrap:
  - burst_start with addr 7, then writes 8'h11, 8'h22, 8'h33 -> registers 7, 8, 0 staged, busy=1;
  - commit -> fields 7/8/0 = 11/22/33, busy=0.
REQ-033 Simultaneous write and commit:
  - stage addr 0 = 8'h45;
  - commit together with a write of addr 0 = 8'h46 -> data_out[0]=8'h45, dirty[0]=1;
  - second commit -> 8'h46.
REQ-034 Illegal address: write to addr 12 with data 8'h10 -> wr_err one cycle; dirty and staging unchanged.
REQ-035 BCD check: with RTC_BCD_CHECK_EN, a burst write of 8'h5A -> wr_err, ptr not advanced; the next write 8'h59 lands at the same register. Without the macro, 8'h5A is accepted.
REQ-036 Reset mid-burst: stage 3 registers, commit, start a new burst, assert reset=0 -> all outputs 0 immediately, busy=0; after release, a commit leaves data_out=0.
